// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter and its normalizer.
package shift_pkg;
    localparam int SHIFT_W   = 32;
    localparam int REQ_TAG_W = 4;
    localparam int REQ_AMT_W = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_op_t;

    typedef struct packed {
        logic [SHIFT_W-1:0]   data;
        shift_op_t            op;
        logic [REQ_AMT_W-1:0] amt;
        logic                 imm;
        logic                 cin;
        logic [REQ_TAG_W-1:0] tag;
    } shift_req_t;
endpackage

// File: rtl/shift_norm.sv
// Combinational ARM shift normalization: picks the shifter amount, or a bypass
// value when the result is fixed by the encoding, plus the carry source.
module shift_norm
    import shift_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [SHIFT_W-1:0] i_data,
    input  shift_op_t          i_op,
    input  logic [AMT_W-1:0]   i_amt,
    input  logic               i_imm,
    input  logic               i_cin,
    output logic [SHIFT_W-1:0] o_sh_amt,
    output logic               o_bypass,
    output logic [SHIFT_W-1:0] o_byp_val,
    output logic               o_carry_val,
    output logic               o_carry_res31
);
    localparam logic [AMT_W:0] AMT_32 = (AMT_W+1)'(32);

    logic           w_zero;
    logic [AMT_W:0] w_eff;
    logic [4:0]     w_lo;
    logic [4:0]     w_idx_l;
    logic [4:0]     w_idx_r;

    assign w_zero  = (i_amt == {AMT_W{1'b0}});
    // Immediate LSR/ASR #0 encode a shift by 32; other #0 forms are caught below.
    assign w_eff   = w_zero ? AMT_32 : {1'b0, i_amt};
    assign w_lo    = w_eff[4:0];
    assign w_idx_l = 5'd0 - w_lo;
    assign w_idx_r = w_lo - 5'd1;

    // Select shifter amount or override value and the carry source.
    always_comb begin
        o_sh_amt      = {SHIFT_W{1'b0}};
        o_bypass      = 1'b1;
        o_byp_val     = i_data;
        o_carry_val   = i_cin;
        o_carry_res31 = 1'b0;
        if (w_zero && (!i_imm || i_op == SH_LSL)) begin
            o_carry_val = i_cin;
        end else if (w_zero && i_op == SH_ROR) begin
            o_byp_val   = {i_cin, i_data[SHIFT_W-1:1]};
            o_carry_val = i_data[0];
        end else begin
            case (i_op)
                SH_LSL: begin
                    if (w_eff < AMT_32) begin
                        o_bypass    = 1'b0;
                        o_sh_amt    = {{(SHIFT_W-5){1'b0}}, w_lo};
                        o_carry_val = i_data[w_idx_l];
                    end else begin
                        o_byp_val   = {SHIFT_W{1'b0}};
                        o_carry_val = (w_eff == AMT_32) & i_data[0];
                    end
                end
                SH_LSR: begin
                    if (w_eff < AMT_32) begin
                        o_bypass    = 1'b0;
                        o_sh_amt    = {{(SHIFT_W-5){1'b0}}, w_lo};
                        o_carry_val = i_data[w_idx_r];
                    end else begin
                        o_byp_val   = {SHIFT_W{1'b0}};
                        o_carry_val = (w_eff == AMT_32) & i_data[SHIFT_W-1];
                    end
                end
                SH_ASR: begin
                    if (w_eff < AMT_32) begin
                        o_bypass    = 1'b0;
                        o_sh_amt    = {{(SHIFT_W-5){1'b0}}, w_lo};
                        o_carry_val = i_data[w_idx_r];
                    end else begin
                        o_byp_val   = {SHIFT_W{i_data[SHIFT_W-1]}};
                        o_carry_val = i_data[SHIFT_W-1];
                    end
                end
                SH_ROR: begin
                    if (w_lo == 5'd0) begin
                        o_carry_val = i_data[SHIFT_W-1];
                    end else begin
                        o_bypass      = 1'b0;
                        o_sh_amt      = {{(SHIFT_W-5){1'b0}}, w_lo};
                        o_carry_res31 = 1'b1;
                    end
                end
                default: begin
                    o_bypass = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared barrel shifter: accept -> issue -> result.
// Define SHIFT_ARB_FIXED_PRIO_EN to make req0 always win instead of round-robin.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int AMT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               rq_valid,
    output logic [1:0]               rq_ready,
    input  logic [1:0][SHIFT_W-1:0]  rq_data,
    input  logic [1:0][1:0]          rq_op,
    input  logic [1:0][AMT_W-1:0]    rq_amt,
    input  logic [1:0]               rq_imm,
    input  logic [1:0]               rq_cin,
    input  logic [1:0][TAG_W-1:0]    rq_tag,
    output logic [SHIFT_W-1:0]       sh_in,
    output logic [1:0]               sh_op,
    output logic [SHIFT_W-1:0]       sh_amt,
    input  logic [SHIFT_W-1:0]       sh_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SHIFT_W-1:0]       res_data,
    output logic                     res_carry,
    output logic                     res_src,
    output logic [TAG_W-1:0]         res_tag
);
    logic               r_iss_valid;
    logic [SHIFT_W-1:0] r_iss_data;
    shift_op_t          r_iss_op;
    logic [AMT_W-1:0]   r_iss_amt;
    logic               r_iss_imm;
    logic               r_iss_cin;
    logic [TAG_W-1:0]   r_iss_tag;
    logic               r_iss_src;

    logic               r_res_valid;
    logic [SHIFT_W-1:0] r_res_data;
    logic               r_res_carry;
    logic               r_res_src;
    logic [TAG_W-1:0]   r_res_tag;

    logic               w_adv_res;
    logic               w_iss_adv;
    logic               w_can_acc;
    logic               w_gnt;
    logic               w_accept;
    logic               w_bypass;
    logic [SHIFT_W-1:0] w_byp_val;
    logic               w_carry_val;
    logic               w_carry_res31;
    logic [SHIFT_W-1:0] w_res_data;
    logic               w_res_carry;

    assign w_adv_res = !r_res_valid | res_ready;
    assign w_iss_adv = r_iss_valid & w_adv_res;
    assign w_can_acc = (!r_iss_valid | w_iss_adv) & !rst;
    assign w_accept  = w_can_acc & (|rq_valid);

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    assign w_gnt = !rq_valid[0];
`else
    logic r_ptr;

    assign w_gnt = (rq_valid == 2'b11) ? r_ptr : !rq_valid[0];

    // Round-robin pointer moves past whichever requester actually transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= !w_gnt;
        end
    end
`endif

    assign rq_ready = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

    // Issue register: loads the granted request, empties when it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_data  <= {SHIFT_W{1'b0}};
            r_iss_op    <= SH_LSL;
            r_iss_amt   <= {AMT_W{1'b0}};
            r_iss_imm   <= 1'b0;
            r_iss_cin   <= 1'b0;
            r_iss_tag   <= {TAG_W{1'b0}};
            r_iss_src   <= 1'b0;
        end else if (w_accept) begin
            r_iss_valid <= 1'b1;
            r_iss_data  <= rq_data[w_gnt];
            r_iss_op    <= shift_op_t'(rq_op[w_gnt]);
            r_iss_amt   <= rq_amt[w_gnt];
            r_iss_imm   <= rq_imm[w_gnt];
            r_iss_cin   <= rq_cin[w_gnt];
            r_iss_tag   <= rq_tag[w_gnt];
            r_iss_src   <= w_gnt;
        end else if (w_iss_adv) begin
            r_iss_valid <= 1'b0;
        end
    end

    shift_norm #(.AMT_W(AMT_W)) u_norm (
        .i_data        (r_iss_data),
        .i_op          (r_iss_op),
        .i_amt         (r_iss_amt),
        .i_imm         (r_iss_imm),
        .i_cin         (r_iss_cin),
        .o_sh_amt      (sh_amt),
        .o_bypass      (w_bypass),
        .o_byp_val     (w_byp_val),
        .o_carry_val   (w_carry_val),
        .o_carry_res31 (w_carry_res31)
    );

    assign sh_in       = r_iss_data;
    assign sh_op       = r_iss_op;
    assign w_res_data  = w_bypass ? w_byp_val : sh_out;
    assign w_res_carry = w_carry_res31 ? w_res_data[SHIFT_W-1] : w_carry_val;

    // Result register: held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= {SHIFT_W{1'b0}};
            r_res_carry <= 1'b0;
            r_res_src   <= 1'b0;
            r_res_tag   <= {TAG_W{1'b0}};
        end else if (w_adv_res) begin
            r_res_valid <= r_iss_valid;
            if (r_iss_valid) begin
                r_res_data  <= w_res_data;
                r_res_carry <= w_res_carry;
                r_res_src   <= r_iss_src;
                r_res_tag   <= r_iss_tag;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_src   = r_res_src;
    assign res_tag   = r_res_tag;
endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, corner sequences
// and randomized traffic against a spec-level reference model.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int TAG_W = 4;
    localparam int AMT_W = 8;

    typedef struct {
        logic [31:0] data;
        logic        c;
        logic        src;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic        src;
        shift_req_t  req;
        logic [31:0] exp_res;
        logic        exp_c;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              rq_valid;
    logic [1:0]              rq_ready;
    logic [1:0][31:0]        rq_data;
    logic [1:0][1:0]         rq_op;
    logic [1:0][AMT_W-1:0]   rq_amt;
    logic [1:0]              rq_imm;
    logic [1:0]              rq_cin;
    logic [1:0][TAG_W-1:0]   rq_tag;
    logic [31:0]             sh_in;
    logic [1:0]              sh_op;
    logic [31:0]             sh_amt;
    logic [31:0]             sh_out;
    logic                    res_valid;
    logic                    res_ready;
    logic [31:0]             res_data;
    logic                    res_carry;
    logic                    res_src;
    logic [TAG_W-1:0]        res_tag;

    shift_arbiter #(.TAG_W(TAG_W), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_data(rq_data), .rq_op(rq_op),
        .rq_amt(rq_amt), .rq_imm(rq_imm), .rq_cin(rq_cin), .rq_tag(rq_tag),
        .sh_in(sh_in), .sh_op(sh_op), .sh_amt(sh_amt), .sh_out(sh_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_src(res_src), .res_tag(res_tag)
    );

    always #5 clk = ~clk;

    // External barrel shifter; an out-of-range amount returns garbage on purpose.
    function automatic logic [31:0] ext_shift(logic [31:0] x, logic [1:0] op, logic [31:0] n);
        if (n == 32'd0 || n > 32'd31) return 32'hDEAD_BEEF;
        case (op)
            2'd0:    return x << n;
            2'd1:    return x >> n;
            2'd2:    return 32'($signed(x) >>> n);
            default: return (x >> n) | (x << (32'd32 - n));
        endcase
    endfunction

    assign sh_out = ext_shift(sh_in, sh_op, sh_amt);

    // Reference result computed from the ARM rules with wide arithmetic.
    function automatic exp_t ref_shift(logic [31:0] x, logic [1:0] op, logic [7:0] a,
                                       logic imm, logic c, logic src, logic [3:0] tag);
        exp_t               e;
        int                 n;
        logic        [63:0] t;
        logic signed [63:0] ts;
        e.src = src;
        e.tag = tag;
        n = int'(a);
        if (imm && a == 8'd0 && op != 2'd0) n = (op == 2'd3) ? -1 : 32;
        if (n == 0) begin
            e.data = x; e.c = c;
        end else if (n < 0) begin
            e.data = {c, x[31:1]}; e.c = x[0];
        end else begin
            case (op)
                2'd0: begin
                    if (n > 32) begin e.data = 32'd0; e.c = 1'b0; end
                    else begin t = {32'd0, x} << n; e.data = t[31:0]; e.c = t[32]; end
                end
                2'd1: begin
                    if (n > 32) begin e.data = 32'd0; e.c = 1'b0; end
                    else begin t = {x, 32'd0} >> n; e.data = t[63:32]; e.c = t[31]; end
                end
                2'd2: begin
                    ts = {x, 32'd0};
                    ts = ts >>> ((n > 32) ? 32 : n);
                    e.data = ts[63:32]; e.c = ts[31];
                end
                default: begin
                    if (n % 32 == 0) begin e.data = x; e.c = x[31]; end
                    else begin
                        e.data = (x >> (n % 32)) | (x << (32 - n % 32));
                        e.c = e.data[31];
                    end
                end
            endcase
        end
        return e;
    endfunction

    int n_pass = 0;
    int n_total = 0;
    int n_pops = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Pipeline model: one issue slot and one result slot, per the stall rules.
    bit          m_iss_full = 1'b0;
    bit          m_res_full = 1'b0;
    bit          m_ptr = 1'b0;
    exp_t        m_iss;
    exp_t        m_res;
    logic [31:0] last_data;
    logic        last_c;
    logic [1:0]  last_rdy;
    logic        last_res_valid;

    task automatic check_and_model();
        logic       adv;
        logic       can;
        logic       g;
        logic [1:0] exp_rdy;
        chk("res_valid", 32'(res_valid), 32'(m_res_full));
        if (m_res_full) begin
            chk("res_data", res_data, m_res.data);
            chk("res_carry", 32'(res_carry), 32'(m_res.c));
            chk("res_src", 32'(res_src), 32'(m_res.src));
            chk("res_tag", 32'(res_tag), 32'(m_res.tag));
        end
        adv = !m_res_full || res_ready;
        can = !m_iss_full || adv;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        g = !rq_valid[0];
`else
        g = (rq_valid == 2'b11) ? m_ptr : !rq_valid[0];
`endif
        exp_rdy = (!rst && can && rq_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("rq_ready", 32'(rq_ready), 32'(exp_rdy));
        last_rdy = rq_ready;
        last_res_valid = res_valid;
        if (rst) begin
            m_iss_full = 1'b0; m_res_full = 1'b0; m_ptr = 1'b0;
        end else begin
            if (m_res_full && res_ready) begin
                n_pops++; last_data = res_data; last_c = res_carry;
            end
            if (adv) begin m_res_full = m_iss_full; m_res = m_iss; end
            if (exp_rdy != 2'b00) begin
                m_iss = ref_shift(rq_data[g], rq_op[g], rq_amt[g], rq_imm[g], rq_cin[g], g, rq_tag[g]);
                m_iss_full = 1'b1;
                m_ptr = !g;
            end else if (adv) begin
                m_iss_full = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int s, logic [31:0] d, logic [1:0] op, logic [7:0] a,
                           logic im, logic c, logic [3:0] t);
        rq_valid[s] = 1'b1; rq_data[s] = d; rq_op[s] = op; rq_amt[s] = a;
        rq_imm[s] = im; rq_cin[s] = c; rq_tag[s] = t;
    endtask

    vec_t vecs[14];

    task automatic mk(int i, logic s, logic [31:0] d, shift_op_t op, logic [7:0] a,
                      logic im, logic c, logic [31:0] r, logic rc);
        vecs[i].src = s;
        vecs[i].req = '{data: d, op: op, amt: a, imm: im, cin: c, tag: 4'(i)};
        vecs[i].exp_res = r;
        vecs[i].exp_c = rc;
    endtask

    initial begin
        int base;
        int nb;
        logic [1:0] exp_g;
        rst = 1'b1; rq_valid = '0; rq_data = '0; rq_op = '0; rq_amt = '0;
        rq_imm = '0; rq_cin = '0; rq_tag = '0; res_ready = 1'b1;

        mk(0,  1'b1, 32'h0000_00F1, SH_LSL, 8'd4,  1'b1, 1'b0, 32'h0000_0F10, 1'b0);
        mk(1,  1'b0, 32'h0000_0003, SH_ROR, 8'd0,  1'b1, 1'b1, 32'h8000_0001, 1'b1);
        mk(2,  1'b0, 32'h8000_0000, SH_LSR, 8'd0,  1'b1, 1'b0, 32'h0000_0000, 1'b1);
        mk(3,  1'b1, 32'h8000_0000, SH_ASR, 8'd40, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        mk(4,  1'b0, 32'h0000_0001, SH_LSL, 8'd32, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        mk(5,  1'b1, 32'h8000_0001, SH_ROR, 8'd32, 1'b0, 1'b0, 32'h8000_0001, 1'b1);
        mk(6,  1'b0, 32'h1234_5678, SH_LSL, 8'd0,  1'b1, 1'b1, 32'h1234_5678, 1'b1);
        mk(7,  1'b1, 32'h0000_0003, SH_LSR, 8'd1,  1'b0, 1'b0, 32'h0000_0001, 1'b1);
        mk(8,  1'b0, 32'hFFFF_FFFF, SH_LSL, 8'd33, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
        mk(9,  1'b1, 32'h7FFF_FFFF, SH_ASR, 8'd0,  1'b1, 1'b1, 32'h0000_0000, 1'b0);
        mk(10, 1'b0, 32'h0000_000F, SH_ROR, 8'd4,  1'b0, 1'b0, 32'hF000_0000, 1'b1);
        mk(11, 1'b1, 32'h8000_0000, SH_LSR, 8'd32, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        mk(12, 1'b0, 32'h0000_0005, SH_ROR, 8'd0,  1'b0, 1'b0, 32'h0000_0005, 1'b0);
        mk(13, 1'b1, 32'h8000_0008, SH_ASR, 8'd4,  1'b0, 1'b0, 32'hF800_0000, 1'b1);

        @(posedge clk); #1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_carry", 32'(res_carry), 32'd0);
        chk("rst_res_src", 32'(res_src), 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);

        // Directed vectors: single request, result expected two cycles after accept.
        foreach (vecs[i]) begin
            base = n_pops;
            set_req(int'(vecs[i].src), vecs[i].req.data, vecs[i].req.op, vecs[i].req.amt,
                    vecs[i].req.imm, vecs[i].req.cin, vecs[i].req.tag);
            step();
            rq_valid = 2'b00;
            step();
            step();
            chk($sformatf("vec%0d_pop", i), 32'(n_pops - base), 32'd1);
            chk($sformatf("vec%0d_res", i), last_data, vecs[i].exp_res);
            chk($sformatf("vec%0d_carry", i), 32'(last_c), 32'(vecs[i].exp_c));
        end

        // Both requesters valid every cycle: alternating grants, no bubbles.
        rst = 1'b1; step(); rst = 1'b0;
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            set_req(0, $urandom, 2'd0, 8'(k + 1), 1'b0, 1'b0, 4'(k));
            set_req(1, $urandom, 2'd1, 8'(k + 2), 1'b0, 1'b1, 4'(k + 8));
            step();
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk($sformatf("alt_gnt%0d", k), 32'(last_rdy), 32'(exp_g));
            if (k >= 2 && last_res_valid) nb++;
        end
        chk("alt_no_bubble", 32'(nb), 32'd6);
        rq_valid = 2'b00;
        repeat (3) step();

        // Consumer stall with two queued requests.
        res_ready = 1'b0;
        base = n_pops;
        for (int k = 0; k < 5; k++) begin
            set_req(0, $urandom, 2'd2, 8'd3, 1'b0, 1'b0, 4'(k));
            set_req(1, $urandom, 2'd3, 8'd7, 1'b0, 1'b0, 4'(k + 5));
            step();
            if (k >= 2) chk($sformatf("stall_rdy%0d", k), 32'(last_rdy), 32'd0);
        end
        rq_valid = 2'b00;
        res_ready = 1'b1;
        repeat (4) step();
        chk("stall_drain", 32'(n_pops - base), 32'd2);

        // Reset with issue and result both full and the pointer at req1.
        res_ready = 1'b0;
        rq_valid = 2'b00;
        set_req(0, 32'h0000_00FF, 2'd0, 8'd1, 1'b0, 1'b0, 4'hA);
        step();
        step();
        set_req(1, 32'h0000_0F00, 2'd1, 8'd2, 1'b0, 1'b0, 4'hB);
        rst = 1'b1;
        step();
        step();
        chk("midrst_res_valid", 32'(last_res_valid), 32'd0);
        chk("midrst_rq_ready", 32'(last_rdy), 32'd0);
        chk("midrst_res_data", res_data, 32'd0);
        rst = 1'b0;
        res_ready = 1'b1;
        step();
        chk("midrst_ptr", 32'(last_rdy), 32'd1);
        rq_valid = 2'b00;
        repeat (3) step();

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 600; k++) begin
            for (int s = 0; s < 2; s++) begin
                logic [7:0] a;
                logic       im;
                case ($urandom_range(0, 3))
                    0:       a = 8'd0;
                    1:       a = 8'($urandom_range(1, 31));
                    2:       a = 8'd32;
                    default: a = 8'($urandom);
                endcase
                im = 1'($urandom);
                if (im) a = a & 8'h1F;
                rq_valid[s] = ($urandom_range(0, 2) != 0);
                rq_data[s] = $urandom;
                rq_op[s] = 2'($urandom);
                rq_amt[s] = a;
                rq_imm[s] = im;
                rq_cin[s] = 1'($urandom);
                rq_tag[s] = 4'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rq_valid = 2'b00;
        res_ready = 1'b1;
        repeat (4) step();
        chk("final_empty", 32'(last_res_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares the single combinational barrel shifter between two requesters: req0 is the data-processing operand2 path, req1 is the load/store offset path.
- Round-robin arbitrates the two requesters and normalizes ARM shift encodings, including #0 special cases, RRX and register amounts ≥32.
- Drives the shifter through a registered issue stage, computes the shifter carry-out, and returns a tagged, registered result with valid/ready backpressure.

Parameters:
- TAG_W, 4, width of the requester tag passed through with each request.
- AMT_W, 8, width of the shift amount field; register form uses Rs[7:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rq_valid  in  2  per-requester request valid
- rq_ready  out  2  per-requester accept; a request transfers when valid&ready
- rq_data  in  2x32  value to shift
- rq_op  in  2x2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- rq_amt  in  2xAMT_W  shift amount
- rq_imm  in  2  1 = immediate-shift form, 0 = register-shift form
- rq_cin  in  2  current CPSR C flag
- rq_tag  in  2xTAG_W  opaque tag
- sh_in  out  32  to shifter shift_in
- sh_op  out  2  to shifter shift_op
- sh_amt  out  32  to shifter shift_amt; zero-extended, always 1..31 when the result is taken from sh_out
- sh_out  in  32  from shifter
- res_valid  out  1  result valid
- res_ready  in  1  consumer accept
- res_data  out  32  shifted value
- res_carry  out  1  shifter carry-out
- res_src  out  1  requester index of the result
- res_tag  out  TAG_W  tag of the result

Behaviour:
- Reset: res_valid=0, res_data=0, res_carry=0, res_src=0, res_tag=0, rq_ready=0, issue stage empty, RR pointer=0 (req0 preferred next).
- Pipeline: accept (cycle N) -> issue register drives sh_* (cycle N+1) -> result register (res_valid high at N+2). Throughput is 1 per cycle with no stalls.
- Stall rules:
  - adv_res = !res_valid | res_ready.
  - The issue stage advances when it is full and adv_res.
  - Accept is allowed when the issue stage is empty or advancing; at most one rq_ready bit is high; rq_ready=0 otherwise.
- Arbitration:
  - Both valid: grant the requester the RR pointer selects; the pointer moves to the other requester only on an actual transfer.
  - One valid: grant it; the pointer moves past it.
- Holding: res_* are held stable while res_valid & !res_ready. sh_* are held while the issue stage is stalled.
- Normalization (a=amt, x=data, c=cin); computed at issue, carry and override registered with the result:
  - imm LSL a=0: res=x, carry=c, shifter bypassed.
  - imm LSR a=0: treat as a=32. imm ASR a=0: treat as a=32. imm ROR a=0: RRX, res={c,x[31:1]}, carry=x[0].
  - reg any op a=0: res=x, carry=c.
  - LSL 1..31: sh_out, carry=x[32-a]. a=32: 0, carry=x[0]. a>32: 0, carry=0.
  - LSR 1..31: sh_out, carry=x[a-1]. a=32: 0, carry=x[31]. a>32: 0, carry=0.
  - ASR 1..31: sh_out, carry=x[a-1]. a≥32: {32{x[31]}}, carry=x[31].
  - ROR reg a≠0, a[4:0]=0: res=x, carry=x[31]. Otherwise sh_amt=a[4:0], res=sh_out, carry=res[31].
- Override cases drive sh_amt=0 and ignore sh_out.
- Reset mid-operation: the issue stage and result are discarded, with no partial result.
- Simultaneous accept and result pop in one cycle is legal and required for full throughput.

Optional Feature:
- Macro SHIFT_ARB_FIXED_PRIO_EN.
- Defined: req0 always wins when both are valid, and the RR pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- shift_pkg: shift_op_t enum (LSL/LSR/ASR/ROR); shift_req_t struct {data, op, amt, imm, cin, tag}; constant SHIFT_W=32.
- One sub-module, shift_norm: combinational normalization producing sh_amt, bypass flag, bypass value and carry-select.

Test Plan:
- req1 only, LSL x=0x0000_00F1 a=4 imm -> res_valid at N+2, res=0x0000_0F10, carry=0, res_src=1.
- Both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1 and back-to-back results with no bubbles. With SHIFT_ARB_FIXED_PRIO_EN: only req0 is granted.
- imm ROR a=0, x=0x0000_0003, cin=1 -> res=0x8000_0001, carry=1. imm LSR a=0, x=0x8000_0000 -> res=0, carry=1.
- reg ASR a=40, x=0x8000_0000 -> res=0xFFFF_FFFF, carry=1. reg LSL a=32, x=1 -> res=0, carry=1. reg ROR a=32, x=0x8000_0001 -> res=x, carry=1.
- res_ready=0 for 3 cycles with two queued requests -> res_* stable, rq_ready=0 after the issue stage fills, no loss or reorder after release.
- Assert rst while the issue stage and result are full -> next cycle res_valid=0, rq_ready=0, RR pointer=0.
